data_sram_slave: RTL and testbench
==================================

Name: data_sram_slave

Overview:
- Data-side SRAM responder for the five-stage core; it is the memory end of the execute stage's data_sram request interface.
- Accepts per-cycle load/store requests with byte write enables.
- Returns load data after a fixed, parameterised latency, flags out-of-window accesses, and keeps saturating access counters.
- Sits between the core's data port and the on-chip data RAM array; the memory stage consumes its read data.

Parameters:
- AW, 10, word-address width; array depth is 2**AW 32-bit words.
- BASE, 32'h0000_0000, byte base address of the window; must be aligned to 4*2**AW.
- RD_LAT, 1, read latency in cycles from request to data_sram_rvalid, legal range 1..4.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- data_sram_en  in  1  read request strobe.
- data_sram_wen  in  4  byte write enables, bit i controls byte lane i (bits 8i+7:8i).
- data_sram_addr  in  32  byte address.
- data_sram_wdata  in  32  store data.
- data_sram_rdata  out  32  load data.
- data_sram_rvalid  out  1  one-cycle pulse when data_sram_rdata carries a new read result.
- data_sram_err  out  1  one-cycle pulse, RD_LAT cycles after an out-of-window request.
- rd_cnt  out  32  saturating count of accepted in-window reads.
- wr_cnt  out  32  saturating count of accepted in-window writes.

Behaviour:
- Reset (reset==0 at a clock edge):
  - rdata=0, rvalid=0, err=0, rd_cnt=0, wr_cnt=0.
  - Read pipeline is cleared; any in-flight read is dropped and produces no rvalid.
  - Array contents are not reset.
- Decode:
  - in_win = (addr[31:AW+2] == BASE[31:AW+2]).
  - Word index = addr[AW+1:2].
  - addr[1:0] is ignored: accesses are word-aligned, and lanes are selected only by wen.
- Write:
  - Happens when wen != 0, independent of en. The core issues stores with en=0.
  - If in_win, each lane with wen[i]=1 is updated at the clock edge; other lanes are unchanged.
  - wr_cnt increments by 1 and saturates at 32'hFFFF_FFFF.
- Read:
  - Accepted when en=1 and wen==0.
  - Data is sampled from the array in the request cycle, after that edge's state, so a write in cycle N followed by a read in cycle N+1 returns the new data.
  - Result appears on rdata with rvalid=1 exactly RD_LAT cycles after the request edge.
  - rd_cnt increments by 1 (saturating).
- Simultaneous en=1 and wen!=0: the write is performed, the read is not, and no rvalid is generated.
- Out-of-window request (write or read, !in_win):
  - No array change and no counter change.
  - err pulses RD_LAT cycles after the request.
  - For a read, rvalid still pulses at the same time with rdata=0, so the fixed-latency consumer never stalls.
- Pipeline:
  - RD_LAT-deep shift register of {valid, err, index}; array read occurs in stage 1.
  - Back-to-back reads every cycle are supported with throughput 1 per cycle.
  - Results return in order.
- Hold behaviour:
  - rdata holds its last value when rvalid=0 and only changes when rvalid=1.
  - err and rvalid are never asserted for more than one cycle per request.
- Idle (en=0, wen=0): no state change except pipeline advance.

Test Plan:
1. Reset then idle → rdata=0, rvalid=0, err=0, rd_cnt=0, wr_cnt=0 for 5 cycles.
2. Byte-lane writes, RD_LAT=1:
   - write addr 0x10, wen=4'b1111, wdata=0xDEADBEEF;
   - next cycle write 0x10, wen=4'b0010, wdata=0x0000AA00;
   - next cycle read 0x10;
   - → one cycle later rvalid=1, rdata=0xDEADAAEF; wr_cnt=2, rd_cnt=1.
3. RD_LAT=3, preloaded words 0x0 and 0x4 (distinct values):
   - reads on 4 consecutive cycles to 0x0, 0x4, 0x0, 0x4;
   - → rvalid high on 4 consecutive cycles starting 3 cycles after the first request;
   - → data in order 0x0, 0x4, 0x0, 0x4 contents.
4. Out-of-window access, AW=10, BASE=0:
   - read 0x0000_1000 → rvalid=1, err=1, rdata=0, rd_cnt unchanged;
   - write 0x0000_1000 → err=1, no rvalid, wr_cnt unchanged, word 0 unmodified.
5. Request with en=1 and wen=4'b1111, addr 0x8, wdata=0x12345678 → no rvalid; subsequent read of 0x8 returns 0x12345678.
6. Reset mid-flight, RD_LAT=2:
   - issue read, then assert reset the next cycle;
   - → no rvalid ever appears for that read; array data is preserved on reread after reset release.

Source files
------------

// File: rtl/data_sram_slave.sv
// Data-side SRAM responder for the five-stage core.
// Serves word-aligned loads with a fixed read latency and byte-lane stores.
// Flags accesses outside the address window and keeps saturating
// counters of accepted in-window reads and writes.
module data_sram_slave #(
   parameter int          AW     = 10,
   parameter logic [31:0] BASE   = 32'h0000_0000,
   parameter int          RD_LAT = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_wen,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   output logic        data_sram_rvalid,
   output logic        data_sram_err,
   output logic [31:0] rd_cnt,
   output logic [31:0] wr_cnt
);

   localparam int DEPTH = 1 << AW;

   // One read-pipeline slot. The array is read as a request enters
   // stage 1, so each slot carries the read word rather than the index.
   // A later store therefore cannot change a read that is already in flight.
   typedef struct packed {
      logic        valid;
      logic        err;
      logic [31:0] data;
   } stage_t;

   logic [31:0] mem [DEPTH];

   logic          in_win;
   logic [AW-1:0] idx;
   logic          is_write;
   logic          is_read;
   logic          unused_addr_bits;

   stage_t pipe     [RD_LAT];
   stage_t pipe_nxt [RD_LAT];

   // The byte offset is ignored. Lanes are chosen only by the write enables.
   assign unused_addr_bits = ^data_sram_addr[1:0];

   assign in_win   = (data_sram_addr[31:AW+2] == BASE[31:AW+2]);
   assign idx      = data_sram_addr[AW+1:2];
   assign is_write = |data_sram_wen;
   assign is_read  = data_sram_en & ~is_write;

   // Build the next pipeline contents: the new request goes into stage 1
   // and every other slot moves down one stage.
   always_comb begin
      for (int k = 0; k < RD_LAT; k++) begin
         pipe_nxt[k] = '0;
      end
      pipe_nxt[0].valid = is_read;
      pipe_nxt[0].err   = (is_read | is_write) & ~in_win;
      pipe_nxt[0].data  = (is_read && in_win) ? mem[idx] : 32'h0;
      for (int k = 1; k < RD_LAT; k++) begin
         pipe_nxt[k] = pipe[k-1];
      end
   end

   // Advance the read pipeline. The load-data register changes only when a
   // result is delivered, so it holds its value between results.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int k = 0; k < RD_LAT; k++) begin
            pipe[k] <= '0;
         end
         data_sram_rdata <= 32'h0;
      end else begin
         for (int k = 0; k < RD_LAT; k++) begin
            pipe[k] <= pipe_nxt[k];
         end
         if (pipe_nxt[RD_LAT-1].valid) begin
            data_sram_rdata <= pipe_nxt[RD_LAT-1].data;
         end
      end
   end

   assign data_sram_rvalid = pipe[RD_LAT-1].valid;
   assign data_sram_err    = pipe[RD_LAT-1].err;

   // Byte-lane store into the array. Contents survive reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (is_write && in_win && data_sram_wen[i]) begin
            mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
         end
      end
   end

   // Saturating counters of accepted in-window reads and writes.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_cnt <= 32'h0;
         wr_cnt <= 32'h0;
      end else begin
         if (is_read && in_win && (rd_cnt != 32'hFFFF_FFFF)) begin
            rd_cnt <= rd_cnt + 32'd1;
         end
         if (is_write && in_win && (wr_cnt != 32'hFFFF_FFFF)) begin
            wr_cnt <= wr_cnt + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_data_sram_slave.sv
// Directed testbench for data_sram_slave.
// Three instances share the same stimulus and differ only in read latency
// (1, 2 and 3 cycles).
module tb_data_sram_slave;

   logic        clk;
   logic        reset;
   logic        en;
   logic [3:0]  wen;
   logic [31:0] addr;
   logic [31:0] wdata;

   logic [31:0] rdata1, rdata2, rdata3;
   logic        rvalid1, rvalid2, rvalid3;
   logic        err1, err2, err3;
   logic [31:0] rd_cnt1, rd_cnt2, rd_cnt3;
   logic [31:0] wr_cnt1, wr_cnt2, wr_cnt3;

   int num_vectors;
   int num_miscompares;

   typedef struct {
      logic        en;
      logic [3:0]  wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        rvalid;
      logic [31:0] rdata;
      logic        err;
      logic [31:0] rd_cnt;
      logic [31:0] wr_cnt;
   } vec_t;

   vec_t vecs [14];

   data_sram_slave #(.AW(10), .BASE(32'h0), .RD_LAT(1)) dut1 (
      .clk(clk), .reset(reset), .data_sram_en(en), .data_sram_wen(wen),
      .data_sram_addr(addr), .data_sram_wdata(wdata),
      .data_sram_rdata(rdata1), .data_sram_rvalid(rvalid1), .data_sram_err(err1),
      .rd_cnt(rd_cnt1), .wr_cnt(wr_cnt1)
   );

   data_sram_slave #(.AW(10), .BASE(32'h0), .RD_LAT(2)) dut2 (
      .clk(clk), .reset(reset), .data_sram_en(en), .data_sram_wen(wen),
      .data_sram_addr(addr), .data_sram_wdata(wdata),
      .data_sram_rdata(rdata2), .data_sram_rvalid(rvalid2), .data_sram_err(err2),
      .rd_cnt(rd_cnt2), .wr_cnt(wr_cnt2)
   );

   data_sram_slave #(.AW(10), .BASE(32'h0), .RD_LAT(3)) dut3 (
      .clk(clk), .reset(reset), .data_sram_en(en), .data_sram_wen(wen),
      .data_sram_addr(addr), .data_sram_wdata(wdata),
      .data_sram_rdata(rdata3), .data_sram_rvalid(rvalid3), .data_sram_err(err3),
      .rd_cnt(rd_cnt3), .wr_cnt(wr_cnt3)
   );

   // Free-running clock with a 10-time-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one request for a cycle, then wait until just after the edge.
   task automatic applyStimulus(input logic e, input logic [3:0] w,
                                input logic [31:0] a, input logic [31:0] d);
      en    = e;
      wen   = w;
      addr  = a;
      wdata = d;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      num_vectors++;
      if (act !== exp) begin
         num_miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Check every output of the 1-cycle-latency instance.
   task automatic checkDut1(input string tag, input logic rv, input logic [31:0] rd,
                            input logic er, input logic [31:0] rc, input logic [31:0] wc);
      checkOutput({tag, ".rvalid"}, {31'h0, rvalid1}, {31'h0, rv});
      checkOutput({tag, ".rdata"},  rdata1,           rd);
      checkOutput({tag, ".err"},    {31'h0, err1},    {31'h0, er});
      checkOutput({tag, ".rd_cnt"}, rd_cnt1,          rc);
      checkOutput({tag, ".wr_cnt"}, wr_cnt1,          wc);
   endtask

   initial begin
      num_vectors     = 0;
      num_miscompares = 0;

      // Per-cycle vectors for the 1-cycle-latency instance.
      // Each expected value is the output state just after that vector's edge.
      //            en    wen   addr          wdata          rv    rdata          err   rd     wr
      vecs[0]  = '{1'b0, 4'hF, 32'h0000_0000, 32'h1111_1111, 1'b0, 32'h0000_0000, 1'b0, 32'd0, 32'd1};
      vecs[1]  = '{1'b0, 4'hF, 32'h0000_0004, 32'h2222_2222, 1'b0, 32'h0000_0000, 1'b0, 32'd0, 32'd2};
      vecs[2]  = '{1'b0, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 1'b0, 32'd0, 32'd3};
      vecs[3]  = '{1'b0, 4'h2, 32'h0000_0010, 32'h0000_AA00, 1'b0, 32'h0000_0000, 1'b0, 32'd0, 32'd4};
      vecs[4]  = '{1'b1, 4'h0, 32'h0000_0010, 32'h0000_0000, 1'b1, 32'hDEAD_AAEF, 1'b0, 32'd1, 32'd4};
      vecs[5]  = '{1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'hDEAD_AAEF, 1'b0, 32'd1, 32'd4};
      vecs[6]  = '{1'b1, 4'h0, 32'h0000_1000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 32'd1, 32'd4};
      vecs[7]  = '{1'b0, 4'hF, 32'h0000_1000, 32'h5555_5555, 1'b0, 32'h0000_0000, 1'b1, 32'd1, 32'd4};
      vecs[8]  = '{1'b1, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h1111_1111, 1'b0, 32'd2, 32'd4};
      vecs[9]  = '{1'b1, 4'hF, 32'h0000_0008, 32'h1234_5678, 1'b0, 32'h1111_1111, 1'b0, 32'd2, 32'd5};
      vecs[10] = '{1'b1, 4'h0, 32'h0000_0008, 32'h0000_0000, 1'b1, 32'h1234_5678, 1'b0, 32'd3, 32'd5};
      vecs[11] = '{1'b1, 4'h0, 32'h0000_0013, 32'h0000_0000, 1'b1, 32'hDEAD_AAEF, 1'b0, 32'd4, 32'd5};
      vecs[12] = '{1'b0, 4'h9, 32'h0000_0010, 32'hA1B2_C3D4, 1'b0, 32'hDEAD_AAEF, 1'b0, 32'd4, 32'd6};
      vecs[13] = '{1'b1, 4'h0, 32'h0000_0010, 32'h0000_0000, 1'b1, 32'hA1AD_AAD4, 1'b0, 32'd5, 32'd6};

      // Reset, then idle: all outputs stay at their reset values.
      reset = 1'b0;
      applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
      applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
      reset = 1'b1;
      for (int c = 0; c < 5; c++) begin
         applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
         checkDut1($sformatf("idle%0d", c), 1'b0, 32'h0, 1'b0, 32'd0, 32'd0);
      end

      // Apply the vector table.
      for (int i = 0; i < 14; i++) begin
         applyStimulus(vecs[i].en, vecs[i].wen, vecs[i].addr, vecs[i].wdata);
         checkDut1($sformatf("vec%0d", i), vecs[i].rvalid, vecs[i].rdata,
                   vecs[i].err, vecs[i].rd_cnt, vecs[i].wr_cnt);
      end

      // Let all pipelines drain.
      for (int c = 0; c < 4; c++) begin
         applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
      end

      // Three-cycle latency: back-to-back reads return in order on
      // consecutive cycles, starting at the third edge.
      begin
         logic [31:0] lat3_data [4];
         lat3_data[0] = 32'h1111_1111;
         lat3_data[1] = 32'h2222_2222;
         lat3_data[2] = 32'h1111_1111;
         lat3_data[3] = 32'h2222_2222;
         for (int k = 0; k < 8; k++) begin
            if (k < 4) begin
               applyStimulus(1'b1, 4'h0, (k % 2 == 0) ? 32'h0 : 32'h4, 32'h0);
            end else begin
               applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
            end
            checkOutput($sformatf("lat3_rvalid%0d", k), {31'h0, rvalid3},
                        {31'h0, (k >= 2 && k <= 5)});
            if (k >= 2 && k <= 5) begin
               checkOutput($sformatf("lat3_rdata%0d", k), rdata3, lat3_data[k-2]);
            end
         end
      end

      // Two-cycle latency: a reset on the cycle after a read drops that
      // read, and the array contents survive the reset.
      applyStimulus(1'b1, 4'h0, 32'h0000_0010, 32'h0);
      checkOutput("rst_rvalid_a", {31'h0, rvalid2}, 32'h0);
      reset = 1'b0;
      applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
      checkOutput("rst_rvalid_b", {31'h0, rvalid2}, 32'h0);
      checkOutput("rst_rd_cnt",   rd_cnt2, 32'h0);
      checkOutput("rst_rdata",    rdata1, 32'h0);
      reset = 1'b1;
      for (int c = 0; c < 4; c++) begin
         applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
         checkOutput($sformatf("rst_idle_rvalid%0d", c), {31'h0, rvalid2}, 32'h0);
      end
      applyStimulus(1'b1, 4'h0, 32'h0000_0010, 32'h0);
      checkOutput("reread_rvalid_a", {31'h0, rvalid2}, 32'h0);
      checkDut1("reread_lat1", 1'b1, 32'hA1AD_AAD4, 1'b0, 32'd1, 32'd0);
      applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
      checkOutput("reread_rvalid_b", {31'h0, rvalid2}, 32'h1);
      checkOutput("reread_rdata",    rdata2, 32'hA1AD_AAD4);

      $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_miscompares);
      $finish;
   end

endmodule
